equiv_sweep_ctrl: RTL and testbench

EQUIV_SWEEP_CTRL -- requirements
Module: equiv_sweep_ctrl

---
 rtl/equiv_pkg.sv | 20 ++
 rtl/ej5.sv | 36 +++
 rtl/equiv_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_equiv_sweep_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/equiv_pkg.sv
// Shared types and constants for the exhaustive equivalence sweep controller.
package equiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT,
      CHECK,
      DONE
   } state_t;

   localparam int FM_F = 0;
   localparam int FM_G = 1;
   localparam int FM_H = 2;
   localparam int FM_L = 3;

   localparam int NUM_VECS = 8;
   localparam logic [2:0] LAST_VEC = 3'(NUM_VECS - 1);

endpackage

// File: rtl/ej5.sv
// Four pairs of boolean expressions; each pair is two algebraically equivalent
// forms of the same function of A, B, C, so every pair should always agree.
module ej5 (
   input  logic [2:0] abc,
   output logic       f,
   output logic       fb,
   output logic       g,
   output logic       gb,
   output logic       h,
   output logic       hb,
   output logic       l,
   output logic       lb
);

   logic a;
   logic b;
   logic c;

   assign a = abc[2];
   assign b = abc[1];
   assign c = abc[0];

   assign f  = a & b;
   assign fb = ~(~a | ~b);

   assign g  = a ^ b;
   assign gb = (a & ~b) | (~a & b);

   // distributive law: C + AB == (C + A)(C + B)
   assign h  = c | (a & b);
   assign hb = (c | a) & (c | b);

   assign l  = ~(a & c);
   assign lb = ~a | ~c;

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// Walks all eight {A,B,C} vectors through the ej5 pairs and records mismatches.
// Optional build macro EQUIV_PIPE_EN registers the datapath outputs before compare.
module equiv_sweep_ctrl
   import equiv_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [3:0] err_count,
   output logic [2:0] first_fail_vec,
   output logic [2:0] abc
);

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state;
   logic [3:0] hold_cnt;
   logic [3:0] mism;

   logic f, fb, g, gb, h, hb, l, lb;
   logic cf, cfb, cg, cgb, ch, chb, cl, clb;

   ej5 u_dp (
      .abc (abc),
      .f   (f),
      .fb  (fb),
      .g   (g),
      .gb  (gb),
      .h   (h),
      .hb  (hb),
      .l   (l),
      .lb  (lb)
   );

`ifdef EQUIV_PIPE_EN
   // Registered copy of the pair outputs; the WAIT state gives it a cycle to settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         {cf, cfb, cg, cgb, ch, chb, cl, clb} <= '0;
      end else begin
         {cf, cfb, cg, cgb, ch, chb, cl, clb} <= {f, fb, g, gb, h, hb, l, lb};
      end
   end
`else
   assign {cf, cfb, cg, cgb, ch, chb, cl, clb} = {f, fb, g, gb, h, hb, l, lb};
`endif

   assign mism[FM_F] = cf ^ cfb;
   assign mism[FM_G] = cg ^ cgb;
   assign mism[FM_H] = ch ^ chb;
   assign mism[FM_L] = cl ^ clb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         abc            <= '0;
         hold_cnt       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_mask      <= '0;
         err_count      <= '0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state          <= APPLY;
                  abc            <= '0;
                  hold_cnt       <= '0;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  fail_mask      <= '0;
                  err_count      <= '0;
                  first_fail_vec <= '0;
               end
            end
            APPLY: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
`ifdef EQUIV_PIPE_EN
                  state    <= WAIT;
`else
                  state    <= CHECK;
`endif
               end else begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
            WAIT: begin
               state <= CHECK;
            end
            CHECK: begin
               fail_mask <= fail_mask | mism;
               // err_count is still zero exactly until the first failing vector
               if (|mism) begin
                  if (err_count != 4'(NUM_VECS))
                     err_count <= err_count + 4'd1;
                  if (err_count == 4'd0)
                     first_fail_vec <= abc;
               end
               if (abc == LAST_VEC) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= ((fail_mask | mism) == 4'd0);
               end else begin
                  abc   <= abc + 3'd1;
                  state <= APPLY;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Directed self-checking bench for equiv_sweep_ctrl at HOLD_CYCLES of 1 and 3;
// datapath faults are planted by forcing one ej5 output.
module tb_equiv_sweep_ctrl;

`ifdef EQUIV_PIPE_EN
   localparam int LAT1 = 25;
   localparam int LAT3 = 41;
`else
   localparam int LAT1 = 17;
   localparam int LAT3 = 33;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0;
   logic       start3 = 1'b0;

   logic       busy1, done1, pass1;
   logic [3:0] fail_mask1, err_count1;
   logic [2:0] first_fail_vec1, abc1;
   logic       busy3, done3, pass3;
   logic [3:0] fail_mask3, err_count3;
   logic [2:0] first_fail_vec3, abc3;

   int errors = 0;
   int checks = 0;
   int sel = 1;
   int done_cyc;
   int pulses;
   bit found;

   logic       m_done, m_pass;
   logic [3:0] m_fail_mask, m_err_count;
   logic [2:0] m_first_fail_vec, m_abc;

   always #5 clk = ~clk;

   equiv_sweep_ctrl #(.HOLD_CYCLES(1)) dut1 (
      .clk            (clk),
      .rst            (rst),
      .start          (start1),
      .busy           (busy1),
      .done           (done1),
      .pass           (pass1),
      .fail_mask      (fail_mask1),
      .err_count      (err_count1),
      .first_fail_vec (first_fail_vec1),
      .abc            (abc1)
   );

   equiv_sweep_ctrl #(.HOLD_CYCLES(3)) dut3 (
      .clk            (clk),
      .rst            (rst),
      .start          (start3),
      .busy           (busy3),
      .done           (done3),
      .pass           (pass3),
      .fail_mask      (fail_mask3),
      .err_count      (err_count3),
      .first_fail_vec (first_fail_vec3),
      .abc            (abc3)
   );

   assign m_done           = (sel == 1) ? done1 : done3;
   assign m_pass           = (sel == 1) ? pass1 : pass3;
   assign m_fail_mask      = (sel == 1) ? fail_mask1 : fail_mask3;
   assign m_err_count      = (sel == 1) ? err_count1 : err_count3;
   assign m_first_fail_vec = (sel == 1) ? first_fail_vec1 : first_fail_vec3;
   assign m_abc            = (sel == 1) ? abc1 : abc3;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Called #1 after a rising edge; the next edge samples start and counts as cycle 1.
   task automatic apply_stimulus(input bit extra_start, output int dcyc, output int npulse);
      bit extra_sent;
      extra_sent = 1'b0;
      dcyc = -1;
      npulse = 0;
      if (sel == 1) start1 = 1'b1;
      else          start3 = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         start1 = 1'b0;
         start3 = 1'b0;
         if (m_done) begin
            npulse++;
            if (dcyc < 0) dcyc = k;
         end
         if (extra_start && !extra_sent && m_abc == 3'd3) begin
            extra_sent = 1'b1;
            if (sel == 1) start1 = 1'b1;
            else          start3 = 1'b1;
         end
      end
   endtask

   task automatic check_results(input string tag, input logic p, input logic [3:0] fm,
                                input logic [3:0] ec, input logic [2:0] ffv);
      check_output({tag, "_pass"}, 32'(m_pass), 32'(p));
      check_output({tag, "_fail_mask"}, 32'(m_fail_mask), 32'(fm));
      check_output({tag, "_err_count"}, 32'(m_err_count), 32'(ec));
      check_output({tag, "_first_fail_vec"}, 32'(m_first_fail_vec), 32'(ffv));
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sel = 1;
      check_output("reset_busy", 32'(busy1), 32'd0);
      check_output("reset_done", 32'(done1), 32'd0);
      check_output("reset_abc", 32'(abc1), 32'd0);
      check_results("reset", 1'b0, 4'd0, 4'd0, 3'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Clean sweep with a stray start at abc=3 that must be ignored.
      apply_stimulus(1'b1, done_cyc, pulses);
      check_output("clean_latency", 32'(done_cyc), 32'(LAT1));
      check_output("clean_done_pulses", 32'(pulses), 32'd1);
      check_results("clean", 1'b1, 4'b0000, 4'd0, 3'd0);

      force dut1.u_dp.fb = 1'b0;
      apply_stimulus(1'b0, done_cyc, pulses);
      release dut1.u_dp.fb;
      check_output("fb0_latency", 32'(done_cyc), 32'(LAT1));
      check_results("fb0", 1'b0, 4'b0001, 4'd2, 3'd6);
      repeat (3) @(posedge clk);
      #1;
      check_output("fb0_hold_fail_mask", 32'(fail_mask1), 32'b0001);

      force dut1.u_dp.hb = 1'b1;
      apply_stimulus(1'b0, done_cyc, pulses);
      release dut1.u_dp.hb;
      check_results("hb1", 1'b0, 4'b0100, 4'd3, 3'd0);

      // Reset mid-sweep once abc reaches 5 with mismatches already recorded.
      force dut1.u_dp.hb = 1'b1;
      found = 1'b0;
      start1 = 1'b1;
      for (int k = 0; k < 40 && !found; k++) begin
         @(posedge clk);
         #1;
         start1 = 1'b0;
         if (abc1 == 3'd5) found = 1'b1;
      end
      check_output("midrst_reached_abc5", 32'(found), 32'd1);
      check_output("midrst_busy_before", 32'(busy1), 32'd1);
      check_output("midrst_err_before", 32'(err_count1), 32'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      release dut1.u_dp.hb;
      check_output("midrst_busy", 32'(busy1), 32'd0);
      check_output("midrst_abc", 32'(abc1), 32'd0);
      check_output("midrst_done", 32'(done1), 32'd0);
      check_results("midrst", 1'b0, 4'd0, 4'd0, 3'd0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done1) pulses++;
      end
      check_output("midrst_no_done", 32'(pulses), 32'd0);
      apply_stimulus(1'b0, done_cyc, pulses);
      check_output("after_rst_latency", 32'(done_cyc), 32'(LAT1));
      check_results("after_rst", 1'b1, 4'd0, 4'd0, 3'd0);

      sel = 3;
      #0;
      apply_stimulus(1'b0, done_cyc, pulses);
      check_output("hold3_latency", 32'(done_cyc), 32'(LAT3));
      check_output("hold3_done_pulses", 32'(pulses), 32'd1);
      check_results("hold3", 1'b1, 4'd0, 4'd0, 3'd0);

      force dut3.u_dp.fb = 1'b0;
      apply_stimulus(1'b0, done_cyc, pulses);
      release dut3.u_dp.fb;
      check_output("hold3_fb0_latency", 32'(done_cyc), 32'(LAT3));
      check_results("hold3_fb0", 1'b0, 4'b0001, 4'd2, 3'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
